// File: rtl/mvm_bn_res_post.sv
// Post-processing for the MVM engine: per-channel BN, residual add/mul/bypass, requantise, ReLU.
// Build option BN_RES_ROUND_EN: every right shift rounds half-up instead of truncating.
module mvm_bn_res_post #(
    parameter int TOUT    = 8,
    parameter int ACC_DW  = 32,
    parameter int DAT_DW  = 16,
    parameter int BN_DW   = 16,
    parameter int CHG_MAX = 64,
    parameter int PIX_W   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_start,
    input  logic [$clog2(CHG_MAX+1)-1:0]     cfg_ch_groups,
    input  logic [PIX_W-1:0]                 cfg_pixels,
    input  logic [1:0]                       cfg_ew_mode,
    input  logic                             cfg_relu_en,
    input  logic [4:0]                       cfg_wt_shift,
    input  logic [4:0]                       cfg_bias_shift,
    input  logic [4:0]                       cfg_res_shift,
    input  logic [4:0]                       cfg_out_shift,
    input  logic                             bn_valid,
    output logic                             bn_ready,
    input  logic [TOUT*2*BN_DW-1:0]          bn_data,
    input  logic                             acc_valid,
    output logic                             acc_ready,
    input  logic [TOUT*ACC_DW-1:0]           acc_data,
    input  logic                             res_valid,
    output logic                             res_ready,
    input  logic [TOUT*DAT_DW-1:0]           res_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TOUT*DAT_DW-1:0]           out_data,
    output logic                             busy,
    output logic                             done
);
    localparam int CGW = $clog2(CHG_MAX+1);
    localparam int AW  = (CHG_MAX > 1) ? $clog2(CHG_MAX) : 1;
    localparam int IW  = ACC_DW + BN_DW + DAT_DW + 2;
    localparam logic signed [IW-1:0] SAT_MAX = IW'((64'sd1 <<< (DAT_DW-1)) - 64'sd1);
    localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

    // state  | meaning
    // IDLE   | waiting for cfg_start
    // LOAD   | accepting cfg_ch_groups BN beats
    // RUN    | streaming acc/res beats through the 3-stage pipe
    // DONE   | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
    state_t r_state, w_nxt;

    logic [CGW-1:0]   r_groups, r_ld_cnt, r_grp;
    logic [PIX_W-1:0] r_pixels, r_pix;
    logic [1:0]       r_mode;
    logic             r_relu, r_all_in;
    logic [4:0]       r_ws, r_bs, r_rs, r_os;

    logic [TOUT*2*BN_DW-1:0] r_bn_mem [CHG_MAX];
    logic [TOUT*2*BN_DW-1:0] w_bn_cur;

    logic                    r_v1, r_v2, r_v3;
    logic signed [IW-1:0]    r_s1_y [TOUT];
    logic [TOUT*DAT_DW-1:0]  r_s1_r;
    logic signed [IW-1:0]    r_s2_z [TOUT];
    logic [TOUT*DAT_DW-1:0]  r_out;
    logic signed [IW-1:0]    w_y [TOUT];
    logic signed [IW-1:0]    w_z [TOUT];
    logic [TOUT*DAT_DW-1:0]  w_q;

    logic w_adv, w_in_rdy, w_byp, w_bn_fire, w_acc_fire, w_last_out;

    function automatic logic signed [IW-1:0] f_rsh(input logic signed [IW-1:0] x, input logic [4:0] s);
`ifdef BN_RES_ROUND_EN
        logic signed [IW-1:0] v_rnd;
        v_rnd = (s == 5'd0) ? '0 : (IW'(1) <<< (s - 5'd1));
        return (x + v_rnd) >>> s;
`else
        return x >>> s;
`endif
    endfunction

    function automatic logic [DAT_DW-1:0] f_post(input logic signed [IW-1:0] z, input logic [4:0] s,
                                                 input logic relu);
        logic signed [IW-1:0] v_sh;
        logic [DAT_DW-1:0]    v_q;
        v_sh = f_rsh(z, s);
        if (v_sh > SAT_MAX)      v_q = SAT_MAX[DAT_DW-1:0];
        else if (v_sh < SAT_MIN) v_q = SAT_MIN[DAT_DW-1:0];
        else                     v_q = v_sh[DAT_DW-1:0];
        return (relu && v_q[DAT_DW-1]) ? '0 : v_q;
    endfunction

    assign w_byp      = r_mode[1];
    assign w_adv      = !(r_v3 && !out_ready);
    assign w_in_rdy   = (r_state == S_RUN) && !r_all_in && w_adv;
    assign w_bn_fire  = bn_valid && bn_ready;
    assign w_acc_fire = acc_valid && acc_ready;
    assign w_last_out = r_all_in && r_v3 && out_ready && !r_v2 && !r_v1;
    assign w_bn_cur   = r_bn_mem[r_grp[AW-1:0]];
    assign out_valid  = r_v3;
    assign out_data   = r_out;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (cfg_start)
                        w_nxt = (cfg_ch_groups == '0 || cfg_pixels == '0) ? S_DONE : S_LOAD;
            S_LOAD: if (w_bn_fire && r_ld_cnt == r_groups - CGW'(1)) w_nxt = S_RUN;
            S_RUN:  if (w_last_out) w_nxt = S_DONE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Readies in add/mul wait for both streams so neither is consumed alone.
    always_comb begin
        bn_ready  = (r_state == S_LOAD);
        acc_ready = w_byp ? w_in_rdy : (w_in_rdy && acc_valid && res_valid);
        res_ready = w_byp ? 1'b0     : (w_in_rdy && acc_valid && res_valid);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_groups <= '0; r_pixels <= '0; r_mode <= '0; r_relu <= 1'b0;
            r_ws <= '0; r_bs <= '0; r_rs <= '0; r_os <= '0;
            r_ld_cnt <= '0; r_pix <= '0; r_grp <= '0; r_all_in <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_ld_cnt <= '0; r_pix <= '0; r_grp <= '0; r_all_in <= 1'b0;
                if (cfg_start) begin
                    r_groups <= cfg_ch_groups; r_pixels <= cfg_pixels;
                    r_mode <= cfg_ew_mode; r_relu <= cfg_relu_en;
                    r_ws <= cfg_wt_shift; r_bs <= cfg_bias_shift;
                    r_rs <= cfg_res_shift; r_os <= cfg_out_shift;
                end
            end
            if (w_bn_fire) r_ld_cnt <= r_ld_cnt + CGW'(1);
            if (w_acc_fire) begin
                if (r_pix == r_pixels - PIX_W'(1)) begin
                    r_pix <= '0;
                    if (r_grp == r_groups - CGW'(1)) r_all_in <= 1'b1;
                    else                             r_grp    <= r_grp + CGW'(1);
                end else begin
                    r_pix <= r_pix + PIX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_bn_fire) r_bn_mem[r_ld_cnt[AW-1:0]] <= bn_data;
    end

    always_comb begin
        for (int i = 0; i < TOUT; i++) begin
            w_y[i] = f_rsh(IW'($signed(acc_data[i*ACC_DW +: ACC_DW])) *
                           IW'($signed(w_bn_cur[2*i*BN_DW +: BN_DW])) +
                           (IW'($signed(w_bn_cur[(2*i+1)*BN_DW +: BN_DW])) <<< r_bs), r_ws);
            unique case (r_mode)
                2'd0:    w_z[i] = r_s1_y[i] + (IW'($signed(r_s1_r[i*DAT_DW +: DAT_DW])) <<< r_rs);
                2'd1:    w_z[i] = f_rsh(r_s1_y[i] * IW'($signed(r_s1_r[i*DAT_DW +: DAT_DW])), r_rs);
                default: w_z[i] = r_s1_y[i];
            endcase
            w_q[i*DAT_DW +: DAT_DW] = f_post(r_s2_z[i], r_os, r_relu);
        end
    end

    // The whole pipe moves together; a stalled stage 3 freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_out <= '0;
        end else if (w_adv) begin
            r_v1   <= w_acc_fire;
            r_v2   <= r_v1;
            r_v3   <= r_v2;
            r_s1_y <= w_y;
            r_s1_r <= res_data;
            r_s2_z <= w_z;
            if (r_v2) r_out <= w_q;
        end
    end
endmodule

// File: tb/tb_mvm_bn_res_post.sv
// Scoreboard bench for mvm_bn_res_post: directed vectors plus a randomised backpressure run.
module tb_mvm_bn_res_post;
    localparam int TOUT = 8, ACC_DW = 32, DAT_DW = 16, BN_DW = 16, CHG_MAX = 64, PIX_W = 16;
    localparam int CGW = $clog2(CHG_MAX+1);

    logic clk = 1'b0, rst = 1'b1;
    logic cfg_start = 1'b0;
    logic [CGW-1:0] cfg_ch_groups = '0;
    logic [PIX_W-1:0] cfg_pixels = '0;
    logic [1:0] cfg_ew_mode = '0;
    logic cfg_relu_en = 1'b0;
    logic [4:0] cfg_wt_shift = '0, cfg_bias_shift = '0, cfg_res_shift = '0, cfg_out_shift = '0;
    logic bn_valid = 1'b0, bn_ready;
    logic [TOUT*2*BN_DW-1:0] bn_data = '0;
    logic acc_valid = 1'b0, acc_ready;
    logic [TOUT*ACC_DW-1:0] acc_data = '0;
    logic res_valid = 1'b0, res_ready;
    logic [TOUT*DAT_DW-1:0] res_data = '0;
    logic out_valid, out_ready;
    logic [TOUT*DAT_DW-1:0] out_data;
    logic busy, done;

    mvm_bn_res_post #(.TOUT(TOUT), .ACC_DW(ACC_DW), .DAT_DW(DAT_DW), .BN_DW(BN_DW),
                      .CHG_MAX(CHG_MAX), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ch_groups(cfg_ch_groups),
        .cfg_pixels(cfg_pixels), .cfg_ew_mode(cfg_ew_mode), .cfg_relu_en(cfg_relu_en),
        .cfg_wt_shift(cfg_wt_shift), .cfg_bias_shift(cfg_bias_shift),
        .cfg_res_shift(cfg_res_shift), .cfg_out_shift(cfg_out_shift),
        .bn_valid(bn_valid), .bn_ready(bn_ready), .bn_data(bn_data),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0, n_out = 0, last_hs = 0;
    logic [127:0] sb [$];
    logic rand_rdy = 1'b0, hold_low = 1'b0;
    int tw [0:7][0:7];
    int tbs [0:7][0:7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rep16(input int v);
        logic [127:0] r;
        for (int i = 0; i < TOUT; i++) r[i*16 +: 16] = 16'(v);
        return r;
    endfunction

    function automatic logic [255:0] rep32(input int v);
        logic [255:0] r;
        for (int i = 0; i < TOUT; i++) r[i*32 +: 32] = 32'(v);
        return r;
    endfunction

    function automatic logic [TOUT*2*BN_DW-1:0] pack_bn(input int g);
        logic [TOUT*2*BN_DW-1:0] v;
        for (int i = 0; i < TOUT; i++) begin
            v[2*i*BN_DW +: BN_DW]     = 16'(tw[g][i]);
            v[(2*i+1)*BN_DW +: BN_DW] = 16'(tbs[g][i]);
        end
        return v;
    endfunction

    function automatic longint m_rsh(input longint x, input int s);
        longint v = x;
`ifdef BN_RES_ROUND_EN
        if (s > 0) v = v + (longint'(1) <<< (s - 1));
`endif
        return v >>> s;
    endfunction

    function automatic logic [15:0] model(input int a, w, b, r, mode, relu, ws, bs, rs, os);
        longint y, z, q;
        y = m_rsh(longint'(a) * longint'(w) + (longint'(b) <<< bs), ws);
        if (mode == 0)      z = y + (longint'(r) <<< rs);
        else if (mode == 1) z = m_rsh(y * longint'(r), rs);
        else                z = y;
        q = m_rsh(z, os);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        if (relu != 0 && q < 0) q = 0;
        return 16'(q);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_bn(input int g, input int w, input int b);
        for (int i = 0; i < TOUT; i++) begin tw[g][i] = w; tbs[g][i] = b; end
    endtask

    // cfg inputs are scrambled after the start edge; the DUT must use the latched copy.
    task automatic start_run(input int g, p, m, relu, ws, bs, rs, os);
        cfg_ch_groups = CGW'(g); cfg_pixels = PIX_W'(p); cfg_ew_mode = 2'(m);
        cfg_relu_en = 1'(relu); cfg_wt_shift = 5'(ws); cfg_bias_shift = 5'(bs);
        cfg_res_shift = 5'(rs); cfg_out_shift = 5'(os);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_ch_groups = 7'd9; cfg_pixels = 16'd3; cfg_ew_mode = 2'd1; cfg_relu_en = ~cfg_relu_en;
        cfg_wt_shift = 5'd7; cfg_bias_shift = 5'd7; cfg_res_shift = 5'd7; cfg_out_shift = 5'd7;
    endtask

    task automatic load_bn(input int n);
        bit ok;
        for (int g = 0; g < n; g++) begin
            bn_valid = 1'b1; bn_data = pack_bn(g);
            ok = 1'b0;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(negedge clk);
                ok = bn_ready;
            end
            if (!ok) chk("bn_ready_timeout", 0, 1);
            tick();
            bn_valid = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [255:0] a, input logic [127:0] r, input int gap, input int rdly);
        bit ok;
        repeat (gap) tick();
        acc_valid = 1'b1; acc_data = a; res_data = r;
        res_valid = (rdly == 0);
        repeat (rdly) tick();
        res_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            ok = acc_ready;
        end
        if (!ok) chk("acc_ready_timeout", 0, 1);
        tick();
        acc_valid = 1'b0; res_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit chk_lat);
        bit seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk({name, "_done_seen"}, seen, 1);
        if (seen) begin
            if (chk_lat) chk({name, "_done_cycle"}, cyc, last_hs + 1);
            @(negedge clk);
            chk({name, "_done_width"}, done, 0);
            chk({name, "_busy_after"}, busy, 0);
        end
        chk({name, "_sb_empty"}, sb.size(), 0);
        tick();
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = hold_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    logic hold_pend = 1'b0;
    logic [127:0] hold_val;
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_val);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_out: got %0h expected no beat", out_data);
                end else begin
                    chk("out_data", out_data, sb.pop_front());
                end
                last_hs = cyc;
                n_out++;
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit saw;
        logic [255:0] a;
        logic [127:0] r, e;
        int av, rv;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_bn_ready", bn_ready, 0);
        chk("rst_acc_ready", acc_ready, 0);
        chk("rst_res_ready", res_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();

        // basic BN, bypass: 10*2+3 = 23
        set_bn(0, 2, 3);
        start_run(1, 4, 2, 0, 0, 0, 0, 0);
        chk("basic_busy", busy, 1);
        load_bn(1);
        for (int p = 0; p < 4; p++) begin
            sb.push_back(rep16(23));
            drive_beat(rep32(10), rep16(0), 0, 0);
        end
        wait_done("basic", 1);

        // add: y=5, z=5+(3<<1)=11, out=11>>2
        set_bn(0, 1, 0);
        start_run(1, 1, 0, 0, 0, 0, 1, 2);
`ifdef BN_RES_ROUND_EN
        sb.push_back(rep16(3));
`else
        sb.push_back(rep16(2));
`endif
        load_bn(1);
        drive_beat(rep32(5), rep16(3), 0, 0);
        wait_done("add_round", 1);

        // mul saturation both ways
        start_run(1, 2, 1, 0, 0, 0, 0, 0);
        load_bn(1);
        sb.push_back(rep16(32767));
        drive_beat(rep32(30000), rep16(4), 0, 0);
        sb.push_back(rep16(-32768));
        drive_beat(rep32(-30000), rep16(4), 0, 1);
        wait_done("mul_sat", 1);

        start_run(1, 1, 1, 1, 0, 0, 0, 0);
        load_bn(1);
        sb.push_back(rep16(0));
        drive_beat(rep32(-30000), rep16(4), 0, 0);
        wait_done("mul_relu", 1);

        // group indexing: out 1,1,2,2,3,3
        for (int g = 0; g < 3; g++) set_bn(g, g + 1, 0);
        start_run(3, 2, 2, 0, 0, 0, 0, 0);
        load_bn(3);
        for (int g = 0; g < 3; g++)
            for (int p = 0; p < 2; p++) begin
                sb.push_back(rep16(g + 1));
                drive_beat(rep32(1), rep16(0), p, 0);
            end
        wait_done("grp_idx", 1);

        // backpressure and input gaps against the reference model
        rand_rdy = 1'b1;
        for (int g = 0; g < 4; g++)
            for (int i = 0; i < TOUT; i++) begin
                tw[g][i]  = int'($urandom_range(0, 8)) - 4;
                tbs[g][i] = int'($urandom_range(0, 40)) - 20;
            end
        n0 = n_out;
        start_run(4, 19, 0, 1, 1, 2, 1, 1);
        load_bn(4);
        for (int g = 0; g < 4; g++)
            for (int p = 0; p < 19; p++) begin
                for (int i = 0; i < TOUT; i++) begin
                    av = int'($urandom_range(0, 6000)) - 3000;
                    rv = int'($urandom_range(0, 6000)) - 3000;
                    a[i*32 +: 32] = 32'(av);
                    r[i*16 +: 16] = 16'(rv);
                    e[i*16 +: 16] = model(av, tw[g][i], tbs[g][i], rv, 0, 1, 1, 2, 1, 1);
                end
                sb.push_back(e);
                drive_beat(a, r, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
            end
        wait_done("bp", 0);
        chk("bp_count", n_out - n0, 76);
        rand_rdy = 1'b0;
        tick();

        // zero groups / zero pixels: straight to DONE, no handshakes
        for (int z = 0; z < 2; z++) begin
            n0 = n_out;
            saw = 1'b0;
            if (z == 0) start_run(0, 5, 2, 0, 0, 0, 0, 0);
            else        start_run(2, 0, 2, 0, 0, 0, 0, 0);
            acc_valid = 1'b1; bn_valid = 1'b1; res_valid = 1'b1;
            @(negedge clk);
            chk("zero_done", done, 1);
            saw = bn_ready || acc_ready || res_ready || out_valid;
            @(negedge clk);
            saw = saw || bn_ready || acc_ready || res_ready || out_valid;
            chk("zero_no_hs", saw, 0);
            chk("zero_done_width", done, 0);
            chk("zero_no_out", n_out - n0, 0);
            acc_valid = 1'b0; bn_valid = 1'b0; res_valid = 1'b0;
            tick();
        end

        // reset while RUN with the pipe full and stalled
        hold_low = 1'b1;
        set_bn(0, 1, 0); set_bn(1, 1, 0);
        start_run(2, 8, 2, 0, 0, 0, 0, 0);
        load_bn(2);
        for (int p = 0; p < 3; p++) drive_beat(rep32(7), rep16(0), 0, 0);
        acc_valid = 1'b1;
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_acc_ready", acc_ready, 0);
        chk("mrst_bn_ready", bn_ready, 0);
        chk("mrst_done", done, 0);
        tick();
        rst = 1'b0; acc_valid = 1'b0; hold_low = 1'b0;
        tick();

        set_bn(0, 2, 3);
        start_run(1, 4, 2, 0, 0, 0, 0, 0);
        load_bn(1);
        for (int p = 0; p < 4; p++) begin
            sb.push_back(rep16(23));
            drive_beat(rep32(10), rep16(0), 0, 0);
        end
        wait_done("after_rst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
